// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
//   start, kill          : operation request and pipeline flush (master -> slave)
//   operand1, operand2   : rs1 / rs2 values                   (master -> slave)
//   alu_op3              : RV32M func3                        (master -> slave)
//   ready, done, result  : idle flag, completion pulse, value (slave -> master)
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             kill;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [2:0]       alu_op3;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, kill, operand1, operand2, alu_op3,
        input  ready, done, result
    );

    modport slave (
        input  start, kill, operand1, operand2, alu_op3,
        output ready, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and radix-2
// restoring divide on operand magnitudes, followed by a single sign-fix cycle.
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : muldiv_unit_if slave (start/kill/operands/func3 in; ready/done/result out)
//          ready is decoded from the state; done and result are registered.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic             r_neg;
    logic [AW-1:0]    r_acc;     // mul: {product hi, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0] r_opb;     // multiplicand (mul) or divisor (div) magnitude
    logic [WIDTH-1:0] r_result;
    logic             r_done;

    logic             w_sgn1;
    logic             w_sgn2;
    logic             w_neg1;
    logic             w_neg2;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic             w_is_div;
    logic             w_res_neg;
    logic             w_div0;
    logic             w_ovf;
    logic [WIDTH-1:0] w_spec_res;
    logic             w_capture;
    logic             w_spec;
    logic             w_fix;
    logic [WIDTH:0]   w_sum;
    logic [AW-1:0]    w_mul_nxt;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic [AW-1:0]    w_div_nxt;
    logic [AW-1:0]    w_prod;
    logic [WIDTH-1:0] w_fix_res;

    // Operand signedness by func3; only MULHSU mixes signed and unsigned.
    always_comb begin
        w_sgn1 = 1'b0;
        w_sgn2 = 1'b0;
        case (bus.alu_op3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                w_sgn1 = 1'b1;
                w_sgn2 = 1'b1;
            end
            3'b010:  w_sgn1 = 1'b1;
            default: ;
        endcase
    end

    assign w_is_div  = bus.alu_op3[2];
    assign w_neg1    = w_sgn1 & bus.operand1[WIDTH-1];
    assign w_neg2    = w_sgn2 & bus.operand2[WIDTH-1];
    assign w_mag1    = w_neg1 ? -bus.operand1 : bus.operand1;
    assign w_mag2    = w_neg2 ? -bus.operand2 : bus.operand2;
    // Remainder takes the dividend's sign; product and quotient take the XOR.
    assign w_res_neg = (w_is_div & bus.alu_op3[1]) ? w_neg1 : (w_neg1 ^ w_neg2);

    // Divide-by-zero and signed overflow finish without iterating.
    assign w_div0 = w_is_div & (bus.operand2 == '0);
    assign w_ovf  = w_is_div & ~bus.alu_op3[0]
                  & (bus.operand1 == {1'b1, {(WIDTH-1){1'b0}}})
                  & (bus.operand2 == '1);
    always_comb begin
        w_spec_res = '0;
        if (w_div0) begin
            w_spec_res = bus.alu_op3[1] ? bus.operand1 : '1;
        end else begin
            w_spec_res = bus.alu_op3[1] ? '0 : bus.operand1;
        end
    end

    // Shift-add step: conditional add into the upper half, then shift right.
    assign w_sum     = {1'b0, r_acc[AW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

    // Restoring step: the shifted remainder needs one extra bit before the trial subtract.
    assign w_rem_sh  = r_acc[AW-1:WIDTH-1];
    assign w_diff    = w_rem_sh - {1'b0, r_opb};
    assign w_div_nxt = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                     : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

    // Sign fix and result selection.
    always_comb begin
        w_prod    = r_neg ? -r_acc : r_acc;
        w_fix_res = '0;
        case (r_op)
            3'b000:                 w_fix_res = w_prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod[AW-1:WIDTH];
            3'b100, 3'b101:         w_fix_res = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            default:                w_fix_res = r_neg ? -r_acc[AW-1:WIDTH] : r_acc[AW-1:WIDTH];
        endcase
    end

    // Next-state and control decode; kill overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_spec      = 1'b0;
        w_fix       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (w_div0 | w_ovf) begin
                        w_spec = 1'b1;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                w_fix       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (bus.kill) begin
            w_state_nxt = ST_IDLE;
            w_capture   = 1'b0;
            w_spec      = 1'b0;
            w_fix       = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_spec | w_fix;
            if (w_spec) begin
                r_result <= w_spec_res;
            end else if (w_fix) begin
                r_result <= w_fix_res;
            end
            if (w_capture) begin
                r_op  <= bus.alu_op3;
                r_neg <= w_res_neg;
                r_cnt <= '0;
                r_acc <= {{WIDTH{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
                r_opb <= w_is_div ? w_mag2 : w_mag1;
            end else if (bus.kill) begin
                r_cnt <= '0;
            end else if (r_state == ST_CALC) begin
                r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.ready  = (r_state == ST_IDLE);
    assign bus.done   = r_done;
    assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed operations push expected result and
// completion edge; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;
    localparam int         LAT       = 33;

    logic clk;
    logic rst;
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_q[$];
    int          due_q[$];
    string       nm_q[$];

    logic [31:0] m_exp;
    int          m_due;
    string       m_nm;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Monitor: every done pulse must match the oldest expectation, on its expected edge.
    always @(negedge clk) begin
        if (rst && bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done result=%h at edge %0d", bus.result, edge_n);
            end else begin
                m_exp = exp_q.pop_front();
                m_due = due_q.pop_front();
                m_nm  = nm_q.pop_front();
                checks++;
                if (bus.result !== m_exp) begin
                    errors++;
                    $display("FAIL %s result got=%h want=%h", m_nm, bus.result, m_exp);
                end
                checks++;
                if (edge_n != m_due) begin
                    errors++;
                    $display("FAIL %s latency done_edge=%0d want=%0d", m_nm, edge_n, m_due);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic wait_edge(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one operation; start is sampled at the next edge (E0). Returns at the
    // negedge after E0 having checked ready.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [31:0] exp, input int lat,
                         input logic exp_ready, input string nm);
        int e0;
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.alu_op3  = op;
        bus.operand1 = a;
        bus.operand2 = b;
        e0 = edge_n + 1;
        if (push) begin
            exp_q.push_back(exp);
            due_q.push_back(e0 + lat);
            nm_q.push_back(nm);
        end
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.operand1 = $urandom;
        bus.operand2 = $urandom;
        bus.alu_op3  = 3'($urandom_range(0, 7));
        @(negedge clk);
        chk({nm, "_ready"}, {31'd0, bus.ready}, {31'd0, exp_ready});
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
            exp_q.delete();
            due_q.delete();
            nm_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int e;
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.kill     = 1'b0;
        bus.operand1 = '0;
        bus.operand2 = '0;
        bus.alu_op3  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("reset_ready",  {31'd0, bus.ready}, 32'd1);
        chk("reset_done",   {31'd0, bus.done},  32'd0);
        chk("reset_result", bus.result,         32'd0);

        // Multiplies
        issue(OP_MUL,    32'd7,        32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, LAT, 1'b0, "mul_7_m3");
        drain(60);
        issue(OP_MULH,   32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, LAT, 1'b0, "mulh_min_min");
        drain(60);
        issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, LAT, 1'b0, "mulhsu_ones");
        drain(60);
        issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, LAT, 1'b0, "mulhu_ones");
        drain(60);
        issue(OP_MULH,   32'hFFFF_FFFF, 32'd1,         1'b1, 32'hFFFF_FFFF, LAT, 1'b0, "mulh_m1_1");
        drain(60);

        // Divides
        issue(OP_DIV,  32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, LAT, 1'b0, "div_m7_2");
        drain(60);
        issue(OP_REM,  32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFF, LAT, 1'b0, "rem_m7_2");
        drain(60);
        issue(OP_DIVU, 32'd100,       32'd7,         1'b1, 32'd14,        LAT, 1'b0, "divu_100_7");
        drain(60);
        issue(OP_REMU, 32'd100,       32'd7,         1'b1, 32'd2,         LAT, 1'b0, "remu_100_7");
        drain(60);
        issue(OP_DIV,  32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, LAT, 1'b0, "div_7_m2");
        drain(60);
        issue(OP_REM,  32'd7,         32'hFFFF_FFFE, 1'b1, 32'd1,         LAT, 1'b0, "rem_7_m2");
        drain(60);
        issue(OP_DIV,  32'h8000_0000, 32'd1,         1'b1, 32'h8000_0000, LAT, 1'b0, "div_min_1");
        drain(60);

        // Special cases: done on the cycle after E0, unit stays idle
        issue(OP_DIVU, 32'd5,         32'd0,         1'b1, 32'hFFFF_FFFF, 0, 1'b1, "divu_5_0");
        drain(10);
        issue(OP_REM,  32'd5,         32'd0,         1'b1, 32'd5,         0, 1'b1, "rem_5_0");
        drain(10);
        issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 0, 1'b1, "div_ovf");
        drain(10);
        issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0,         0, 1'b1, "rem_ovf");
        drain(10);

        // Back-to-back: DIV issued in the MUL done cycle
        issue(OP_MUL, 32'd3, 32'd4, 1'b1, 32'd12, LAT, 1'b0, "b2b_mul");
        e = edge_n;
        wait_edge(e + LAT);
        chk("b2b_ready_in_done", {31'd0, bus.ready}, 32'd1);
        bus.start    = 1'b1;
        bus.alu_op3  = OP_DIV;
        bus.operand1 = 32'd12;
        bus.operand2 = 32'd4;
        exp_q.push_back(32'd3);
        due_q.push_back(e + LAT + 1 + LAT);
        nm_q.push_back("b2b_div");
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.operand1 = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("b2b_div_ready", {31'd0, bus.ready}, 32'd0);
        wait_edge(e + LAT + 12);
        chk("b2b_result_hold", bus.result, 32'd12);
        drain(60);

        // Kill on cycle 10 of a DIV
        issue(OP_DIVU, 32'd1000, 32'd3, 1'b0, 32'd0, LAT, 1'b0, "kill_div");
        e = edge_n;
        wait_edge(e + 9);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        chk("kill_ready",  {31'd0, bus.ready}, 32'd1);
        chk("kill_done",   {31'd0, bus.done},  32'd0);
        chk("kill_result", bus.result,         32'd3);
        repeat (40) @(negedge clk);
        chk("kill_result_later", bus.result, 32'd3);

        // Kill on the FIX edge drops the pending done
        issue(OP_MUL, 32'd5, 32'd5, 1'b0, 32'd0, LAT, 1'b0, "kill_fix");
        e = edge_n;
        wait_edge(e + LAT - 1);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        @(negedge clk);
        chk("kill_fix_done",   {31'd0, bus.done}, 32'd0);
        chk("kill_fix_result", bus.result,        32'd3);

        // Kill with start in IDLE: nothing starts (normal and special-case requests)
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.kill  = 1'b1;
        bus.alu_op3  = OP_MUL;
        bus.operand1 = 32'd9;
        bus.operand2 = 32'd9;
        @(posedge clk);
        #1;
        chk("kill_start_ready", {31'd0, bus.ready}, 32'd1);
        bus.alu_op3  = OP_DIVU;
        bus.operand2 = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        @(negedge clk);
        chk("kill_start_spec_done", {31'd0, bus.done}, 32'd0);
        repeat (40) @(negedge clk);
        chk("kill_start_result", bus.result, 32'd3);

        // Reset at cycle 20 of a MULHU
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, LAT, 1'b0, "rst_mulhu");
        e = edge_n;
        wait_edge(e + 19);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_done",   {31'd0, bus.done},  32'd0);
        chk("rst_mid_result", bus.result,         32'd0);
        chk("rst_mid_ready",  {31'd0, bus.ready}, 32'd1);
        issue(OP_MUL, 32'd2, 32'd2, 1'b1, 32'd4, LAT, 1'b0, "post_rst_mul");
        drain(60);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit that sits beside the combinational ALU in the execute stage and uses the same operand1/operand2/func3 interface. It executes the eight M-extension operations over multiple cycles through a start/done handshake. The stall logic holds the pipeline while `ready` is low. Multiplication uses radix-2 shift-add and division uses radix-2 restoring division; both run on operand magnitudes, with a final sign-fix cycle.

## Interface
- `WIDTH`, default 32: operand and result width. The counter width is clog2(WIDTH).
- `clk`  in  1  : single clock; all state updates on its rising edge.
- `rst`  in  1  : synchronous, active-low reset.
- `start`  in  1  : operation request. Sampled only when `ready`=1.
- `kill`  in  1  : pipeline flush. Aborts any operation.
- `operand1`  in  WIDTH  : rs1 value (multiplicand/dividend).
- `operand2`  in  WIDTH  : rs2 value (multiplier/divisor).
- `alu_op3`  in  3  : func3. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `ready`  out  1  : unit idle; `start` is accepted this cycle. Decoded combinationally from the state.
- `done`  out  1  : one-cycle pulse; `result` is valid.
- `result`  out  WIDTH  : registered result. Held until the next `done`.

## Operation
- States:
  - IDLE: `ready`=1.
  - CALC: iterating.
  - FIX: sign correction and result load.
- IDLE, `start`=1, `kill`=0: capture the operation, the operand magnitudes, and the result sign.
  - Signedness per operand:
    - MUL/MULH/DIV/REM: both operands signed.
    - MULHSU: operand1 signed, operand2 unsigned.
    - MULHU/DIVU/REMU: both operands unsigned.
  - Result sign:
    - Product: sign1 XOR sign2.
    - Quotient: sign1 XOR sign2.
    - Remainder: sign of the dividend.
- Division special cases bypass CALC. The result loads at the capture edge; state stays IDLE; `done` pulses the next cycle.
  - Divisor 0:
    - DIV/DIVU result = all ones.
    - REM/REMU result = operand1.
  - DIV/REM with operand1 = 0x8000_0000 and operand2 = 0xFFFF_FFFF:
    - DIV result = 0x8000_0000.
    - REM result = 0.
- CALC runs exactly WIDTH iterations; the counter counts 0..WIDTH-1.
  - Multiply: 2*WIDTH-bit accumulator. Each cycle, if multiplier LSB is 1, add the multiplicand into the upper half; then shift the accumulator right by 1.
  - Divide: shift the {remainder, quotient} pair left by 1. Trial-subtract the divisor; if the difference is non-negative, keep it and set the quotient LSB.
- FIX, one cycle. Apply two's-complement negation if the result sign is set, then select the output:
  - MUL: low WIDTH bits of the product.
  - MULH/MULHSU/MULHU: high WIDTH bits of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Load `result`, assert `done`, return to IDLE.
- `kill`=1 in any state: go to IDLE at the next edge and drop any pending `done`; `result` is unchanged. `kill` takes priority over a simultaneous `start`.
- Reset (`rst`=0 at an edge), including mid-operation:
  - State = IDLE.
  - Counter = 0.
  - `result` = 0.
  - `done` = 0.
  - `ready` = 1 from the first cycle after reset.

## Timing
- Normal latency: `start` is sampled at edge E0. CALC spans edges E1..E32 (WIDTH edges), FIX happens at E33, and `done`=1 during the cycle after E33. Total latency is WIDTH+1 edges.
- Special-case latency: `done`=1 during the cycle after E0.
- `ready`=0 from after E0 until FIX completes. In the cycle where `done`=1, state is IDLE and `ready`=1. A `start` in that cycle is accepted, giving back-to-back issue with no bubble.
- Operand and `alu_op3` changes after E0 have no effect on the operation in flight.
- `done` is never high for two consecutive cycles unless two operations completed back-to-back.

## Test plan
- Multiply:
  - MUL 7 × 0xFFFF_FFFD → `result`=0xFFFF_FFEB; `done` exactly 33 cycles after the `start` edge.
  - MULH 0x8000_0000 × 0x8000_0000 → 0x4000_0000.
  - MULHSU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFF.
  - MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE.
- Divide:
  - DIV 0xFFFF_FFF9 / 2 → 0xFFFF_FFFD.
  - REM 0xFFFF_FFF9 / 2 → 0xFFFF_FFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- Special cases, each with `done` one cycle after `start` and `ready` staying 1:
  - DIVU 5 / 0 → 0xFFFF_FFFF.
  - REM 5 / 0 → 5.
  - DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000.
  - REM with the same operands → 0.
- Back-to-back: assert `start` in the `done` cycle of a MUL 3×4=12 with DIV 12/4 → second `done` 33 cycles later with `result`=3; first `result`=12 holds meanwhile.
- `kill` asserted on cycle 10 of a DIV → no `done` pulse, `ready`=1 next cycle, `result` keeps its prior value. `kill`+`start` in IDLE → nothing starts.
- `rst`=0 held for one edge at cycle 20 of a MULHU → `done`=0 and `result`=0 after that edge, `ready`=1. A fresh MUL 2×2 afterwards yields 4.
